// File: rtl/axi_slave_ram_responder.sv
// AXI-style slave endpoint backed by a byte-enabled 32-bit word RAM.
// Independent write and read engines, one outstanding burst each.
module axi_slave_ram_responder #(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        S_CLK,
  input  logic        S_RST,
  input  logic [3:0]  S_WR_ADDR_ID,
  input  logic [31:0] S_WR_ADDR,
  input  logic [7:0]  S_WR_ADDR_LEN,
  input  logic [1:0]  S_WR_ADDR_BURST,
  input  logic        S_WR_ADDR_VALID,
  output logic        S_WR_ADDR_READY,
  input  logic [31:0] S_WR_DATA,
  input  logic [3:0]  S_WR_STRB,
  input  logic        S_WR_DATA_LAST,
  input  logic        S_WR_DATA_VALID,
  output logic        S_WR_DATA_READY,
  output logic [3:0]  S_WR_BACK_ID,
  output logic [1:0]  S_WR_BACK_RESP,
  output logic        S_WR_BACK_VALID,
  input  logic        S_WR_BACK_READY,
  input  logic [3:0]  S_RD_ADDR_ID,
  input  logic [31:0] S_RD_ADDR,
  input  logic [7:0]  S_RD_ADDR_LEN,
  input  logic [1:0]  S_RD_ADDR_BURST,
  input  logic        S_RD_ADDR_VALID,
  output logic        S_RD_ADDR_READY,
  output logic [3:0]  S_RD_BACK_ID,
  output logic [31:0] S_RD_DATA,
  output logic [1:0]  S_RD_DATA_RESP,
  output logic        S_RD_DATA_LAST,
  output logic        S_RD_DATA_VALID,
  input  logic        S_RD_DATA_READY
);

  localparam int unsigned DEPTH     = 32'(1) << MEM_AW;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [31:0] mem_q [DEPTH];

  // write engine state
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_id_q, w_id_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic        w_err_q, w_err_d;
  logic        aw_rdy_q, aw_rdy_d;
  logic        wd_rdy_q, wd_rdy_d;
  logic        b_valid_q, b_valid_d;
  logic [3:0]  b_id_q, b_id_d;
  logic [1:0]  b_resp_q, b_resp_d;

  // read engine state
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic        ar_rdy_q, ar_rdy_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [3:0]  rd_id_q, rd_id_d;
  logic [1:0]  rd_resp_q, rd_resp_d;
  logic        rd_last_q, rd_last_d;

  logic [31:0]       w_off_c, r_off_c;
  logic              w_in_range_c, r_in_range_c;
  logic [MEM_AW-1:0] w_idx_c, r_idx_c;
  logic              mem_we_c;
  logic              w_beat_err_c;

  // Byte offsets into the RAM window and per-beat range checks
  always_comb begin
    w_off_c      = w_addr_q - BASE_ADDR;
    r_off_c      = r_addr_q - BASE_ADDR;
    w_in_range_c = ({1'b0, w_off_c} < MEM_BYTES);
    r_in_range_c = ({1'b0, r_off_c} < MEM_BYTES);
    w_idx_c      = w_off_c[MEM_AW+1:2];
    r_idx_c      = r_off_c[MEM_AW+1:2];
  end

  // Write FSM next-state and registered-output values
  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_burst_d    = w_burst_q;
    w_cnt_d      = w_cnt_q;
    w_err_d      = w_err_q;
    aw_rdy_d     = aw_rdy_q;
    wd_rdy_d     = wd_rdy_q;
    b_valid_d    = b_valid_q;
    b_id_d       = b_id_q;
    b_resp_d     = b_resp_q;
    mem_we_c     = 1'b0;
    w_beat_err_c = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (S_WR_ADDR_VALID && aw_rdy_q) begin
          w_id_d    = S_WR_ADDR_ID;
          w_addr_d  = S_WR_ADDR;
          w_len_d   = S_WR_ADDR_LEN;
          w_burst_d = S_WR_ADDR_BURST;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          aw_rdy_d  = 1'b0;
          wd_rdy_d  = 1'b1;
          w_state_d = W_DATA;
        end else begin
          aw_rdy_d = 1'b1;
        end
      end
      W_DATA: begin
        if (S_WR_DATA_VALID && wd_rdy_q) begin
          mem_we_c     = w_in_range_c;
          w_beat_err_c = !w_in_range_c || (w_burst_q == BURST_RSVD) ||
                         (S_WR_DATA_LAST != (w_cnt_q == w_len_q));
          w_err_d      = w_err_q | w_beat_err_c;
          if (w_cnt_q == w_len_q) begin
            wd_rdy_d  = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = w_id_q;
            b_resp_d  = (w_err_q | w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = (w_burst_q == BURST_FIXED) ? w_addr_q : w_addr_q + 32'd4;
          end
        end
      end
      W_RESP: begin
        if (S_WR_BACK_READY && b_valid_q) begin
          b_valid_d = 1'b0;
          b_id_d    = 4'd0;
          b_resp_d  = RESP_OKAY;
          aw_rdy_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM registers
  always_ff @(posedge S_CLK) begin
    if (S_RST) begin
      w_state_q <= W_IDLE;
      w_id_q    <= 4'd0;
      w_addr_q  <= 32'd0;
      w_len_q   <= 8'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      aw_rdy_q  <= 1'b0;
      wd_rdy_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_id_q    <= 4'd0;
      b_resp_q  <= 2'd0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      aw_rdy_q  <= aw_rdy_d;
      wd_rdy_q  <= wd_rdy_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // RAM write port with byte-lane enables; contents survive reset
  always_ff @(posedge S_CLK) begin
    if (mem_we_c && !S_RST) begin
      for (int b = 0; b < 4; b++) begin
        if (S_WR_STRB[b]) begin
          mem_q[w_idx_c][8*b +: 8] <= S_WR_DATA[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next-state; the beat is captured at the end of R_FETCH (read-first)
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    ar_rdy_d   = ar_rdy_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_resp_d  = rd_resp_q;
    rd_last_d  = rd_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_RD_ADDR_VALID && ar_rdy_q) begin
          r_id_d    = S_RD_ADDR_ID;
          r_addr_d  = S_RD_ADDR;
          r_len_d   = S_RD_ADDR_LEN;
          r_burst_d = S_RD_ADDR_BURST;
          r_cnt_d   = 8'd0;
          ar_rdy_d  = 1'b0;
          r_state_d = R_FETCH;
        end else begin
          ar_rdy_d = 1'b1;
        end
      end
      R_FETCH: begin
        rd_valid_d = 1'b1;
        rd_id_d    = r_id_q;
        rd_last_d  = (r_cnt_q == r_len_q);
        if (!r_in_range_c || (r_burst_q == BURST_RSVD)) begin
          rd_data_d = 32'd0;
          rd_resp_d = RESP_SLVERR;
        end else begin
          rd_data_d = mem_q[r_idx_c];
          rd_resp_d = RESP_OKAY;
        end
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (S_RD_DATA_READY && rd_valid_q) begin
          rd_valid_d = 1'b0;
          rd_data_d  = 32'd0;
          rd_id_d    = 4'd0;
          rd_resp_d  = RESP_OKAY;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            ar_rdy_d  = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            r_addr_d  = (r_burst_q == BURST_FIXED) ? r_addr_q : r_addr_q + 32'd4;
            r_state_d = R_FETCH;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM registers
  always_ff @(posedge S_CLK) begin
    if (S_RST) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= 4'd0;
      r_addr_q   <= 32'd0;
      r_len_q    <= 8'd0;
      r_burst_q  <= 2'd0;
      r_cnt_q    <= 8'd0;
      ar_rdy_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_id_q    <= 4'd0;
      rd_resp_q  <= 2'd0;
      rd_last_q  <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      ar_rdy_q   <= ar_rdy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_resp_q  <= rd_resp_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign S_WR_ADDR_READY = aw_rdy_q;
  assign S_WR_DATA_READY = wd_rdy_q;
  assign S_WR_BACK_VALID = b_valid_q;
  assign S_WR_BACK_ID    = b_id_q;
  assign S_WR_BACK_RESP  = b_resp_q;
  assign S_RD_ADDR_READY = ar_rdy_q;
  assign S_RD_DATA_VALID = rd_valid_q;
  assign S_RD_DATA       = rd_data_q;
  assign S_RD_BACK_ID    = rd_id_q;
  assign S_RD_DATA_RESP  = rd_resp_q;
  assign S_RD_DATA_LAST  = rd_last_q;

endmodule

// File: tb/tb_axi_slave_ram_responder.sv
// Directed bench for axi_slave_ram_responder: bursts, strobes, range errors, stalls, reset.
module tb_axi_slave_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_slave_ram_responder #(.MEM_AW(10), .BASE_ADDR(32'h0000_0000)) dut (
    .S_CLK(clk), .S_RST(rst),
    .S_WR_ADDR_ID(awid), .S_WR_ADDR(awaddr), .S_WR_ADDR_LEN(awlen),
    .S_WR_ADDR_BURST(awburst), .S_WR_ADDR_VALID(awvalid), .S_WR_ADDR_READY(awready),
    .S_WR_DATA(wdata), .S_WR_STRB(wstrb), .S_WR_DATA_LAST(wlast),
    .S_WR_DATA_VALID(wvalid), .S_WR_DATA_READY(wready),
    .S_WR_BACK_ID(bid), .S_WR_BACK_RESP(bresp), .S_WR_BACK_VALID(bvalid),
    .S_WR_BACK_READY(bready),
    .S_RD_ADDR_ID(arid), .S_RD_ADDR(araddr), .S_RD_ADDR_LEN(arlen),
    .S_RD_ADDR_BURST(arburst), .S_RD_ADDR_VALID(arvalid), .S_RD_ADDR_READY(arready),
    .S_RD_BACK_ID(rid), .S_RD_DATA(rdata), .S_RD_DATA_RESP(rresp),
    .S_RD_DATA_LAST(rlast), .S_RD_DATA_VALID(rvalid), .S_RD_DATA_READY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 50) begin step(); n++; end
    chk("aw_ready", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 50) begin step(); n++; end
    chk("w_ready", 32'(wready), 32'd1);
    step();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bid"}, 32'(bid), 32'(id));
    chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  task automatic write_seq(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] s);
    send_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) send_w(d0 + 32'(i), s, (i == int'(len)));
  endtask

  // Address handshake plus the fixed two-cycle first-beat latency
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    chk("ar_ready", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
    chk("r_lat_t1", 32'(rvalid), 32'd0);
    step();
    chk("r_lat_t2", 32'(rvalid), 32'd1);
  endtask

  task automatic recv_r(input string tag, input logic [31:0] d, input logic [3:0] id,
                        input logic [1:0] resp, input logic last);
    int n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_rid"}, 32'(rid), 32'(id));
    chk({tag, "_rresp"}, 32'(rresp), 32'(resp));
    chk({tag, "_rlast"}, 32'(rlast), 32'(last));
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arburst = 2'd0; arvalid = 1'b0;
    rready = 1'b0;
    step(); step(); step();

    // reset state
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_wready", 32'(wready), 32'd0);

    // INCR write and readback of 0x10..0x1C
    write_seq(4'd3, 32'h10, 8'd3, 2'b01, 32'hA0, 4'hF);
    wait_b("t1", 4'd3, 2'b00);
    send_ar(4'd5, 32'h10, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) recv_r("t1", 32'hA0 + 32'(i), 4'd5, 2'b00, (i == 3));

    // byte strobes
    write_seq(4'd1, 32'h20, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF);
    wait_b("t2a", 4'd1, 2'b00);
    write_seq(4'd1, 32'h20, 8'd0, 2'b01, 32'h1234_5678, 4'b0101);
    wait_b("t2b", 4'd1, 2'b00);
    send_ar(4'd2, 32'h20, 8'd0, 2'b01);
    recv_r("t2", 32'hFF34_FF78, 4'd2, 2'b00, 1'b1);

    // FIXED burst: last beat wins
    write_seq(4'd4, 32'h40, 8'd2, 2'b00, 32'd1, 4'hF);
    wait_b("t3", 4'd4, 2'b00);
    send_ar(4'd4, 32'h40, 8'd0, 2'b01);
    recv_r("t3", 32'd3, 4'd4, 2'b00, 1'b1);

    // burst leaving the RAM window
    write_seq(4'd8, 32'hFFC, 8'd1, 2'b01, 32'hCAFE_0001, 4'hF);
    wait_b("t4", 4'd8, 2'b10);
    send_ar(4'd8, 32'hFFC, 8'd1, 2'b01);
    recv_r("t4b0", 32'hCAFE_0001, 4'd8, 2'b00, 1'b0);
    recv_r("t4b1", 32'd0, 4'd8, 2'b10, 1'b1);

    // early LAST: all beats still accepted, SLVERR
    send_aw(4'd7, 32'h100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hB0 + 32'(i), 4'hF, (i == 1) || (i == 3));
    wait_b("t5a", 4'd7, 2'b10);
    send_ar(4'd7, 32'h10C, 8'd0, 2'b01);
    recv_r("t5a", 32'hB3, 4'd7, 2'b00, 1'b1);

    // reserved burst type
    write_seq(4'd2, 32'h200, 8'd0, 2'b11, 32'h55, 4'hF);
    wait_b("t5b", 4'd2, 2'b10);

    // read stall: outputs held while RREADY is low
    send_ar(4'd9, 32'h10, 8'd1, 2'b01);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_rdata", rdata, 32'hA0);
      chk("stall_rid", 32'(rid), 32'd9);
      chk("stall_rlast", 32'(rlast), 32'd0);
      step();
    end
    recv_r("t6b0", 32'hA0, 4'd9, 2'b00, 1'b0);
    recv_r("t6b1", 32'hA1, 4'd9, 2'b00, 1'b1);

    // reset in the middle of a write burst
    send_aw(4'd4, 32'h80, 8'd3, 2'b01);
    send_w(32'hDEAD_0000, 4'hF, 1'b0);
    send_w(32'hDEAD_0001, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_no_b", 32'(bvalid), 32'd0);
    end
    write_seq(4'd6, 32'h300, 8'd0, 2'b01, 32'h77, 4'hF);
    wait_b("t7", 4'd6, 2'b00);
    send_ar(4'd6, 32'h80, 8'd1, 2'b01);
    recv_r("t7b0", 32'hDEAD_0000, 4'd6, 2'b00, 1'b0);
    recv_r("t7b1", 32'hDEAD_0001, 4'd6, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram_responder.md
Name: axi_slave_ram_responder

Overview:
- Single-clock AXI-style slave endpoint with an internal word RAM.
- Terminates the five slave-side channels (write address, write data, write response, read address, read data) that the slave-side clock-domain bridge drives.
- Runs entirely in the slave clock domain. Serves as the default memory slave and as the bench target for bridge and bus bring-up.
- Independent write and read engines, each with one outstanding burst.

Parameters:
MEM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
BASE_ADDR, 32'h0000_0000, byte address mapped to RAM word 0; must be aligned to 4*2^MEM_AW

Ports:
S_CLK  in  1  slave clock
S_RST  in  1  synchronous active-high reset
S_WR_ADDR_ID  in  4  write burst ID
S_WR_ADDR  in  32  write start byte address
S_WR_ADDR_LEN  in  8  beats minus 1
S_WR_ADDR_BURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
S_WR_ADDR_VALID  in  1  write address valid
S_WR_ADDR_READY  out  1  write address accepted
S_WR_DATA  in  32  write data
S_WR_STRB  in  4  byte enables
S_WR_DATA_LAST  in  1  last write beat
S_WR_DATA_VALID  in  1  write data valid
S_WR_DATA_READY  out  1  write data accepted
S_WR_BACK_ID  out  4  response ID
S_WR_BACK_RESP  out  2  00 OKAY, 10 SLVERR
S_WR_BACK_VALID  out  1  response valid
S_WR_BACK_READY  in  1  response accepted
S_RD_ADDR_ID  in  4  read burst ID
S_RD_ADDR  in  32  read start byte address
S_RD_ADDR_LEN  in  8  beats minus 1
S_RD_ADDR_BURST  in  2  burst type
S_RD_ADDR_VALID  in  1  read address valid
S_RD_ADDR_READY  out  1  read address accepted
S_RD_BACK_ID  out  4  read data ID
S_RD_DATA  out  32  read data
S_RD_DATA_RESP  out  2  per-beat response
S_RD_DATA_LAST  out  1  last read beat
S_RD_DATA_VALID  out  1  read data valid
S_RD_DATA_READY  in  1  read data accepted

Behaviour:
- Interface: one clock S_CLK; reset S_RST is synchronous and active-high.
- Reset:
  - All READY and VALID outputs are 0 while S_RST is high and in the cycle it is sampled.
  - BACK_ID, BACK_RESP, RD_DATA, RD_DATA_RESP and RD_DATA_LAST are all 0.
  - Both FSMs return to IDLE. RAM contents are not cleared.
  - Reset mid-burst aborts the burst silently: no response is issued, and beats already written stay in RAM.
- Address map:
  - Word index = (addr - BASE_ADDR)[MEM_AW+1:2]. addr[1:0] is ignored.
  - A beat is in range iff (addr - BASE_ADDR) < 4*2^MEM_AW.
- Beat address update:
  - FIXED: the address stays constant.
  - INCR and WRAP (WRAP is treated as INCR): the address increments by 4, with 32-bit wrap-around.
  - Range is checked per beat, so a burst may leave range partway through.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: WR_ADDR_READY=1. On handshake, latch ID, address, LEN, BURST; clear the beat counter and the error flag; go to W_DATA.
  - W_DATA: WR_DATA_READY=1. Each handshake writes the byte lanes with STRB=1, only when the beat is in range.
  - Error flag is set by: an out-of-range beat; BURST=11; or LAST disagreeing with (count==LEN) on any beat.
  - The burst ends on the beat where count==LEN, regardless of LAST; then go to W_RESP.
  - W_RESP: WR_BACK_VALID=1, BACK_ID = latched ID, RESP = error ? 10 : 00. Hold until READY, then go to W_IDLE.
  - Write-data beats arriving while in W_IDLE are not accepted (READY=0).
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: RD_ADDR_READY=1. On handshake, latch fields; go to R_FETCH.
  - R_FETCH: issue the synchronous RAM read (1-cycle latency); go to R_DATA.
  - R_DATA: RD_DATA_VALID=1 with registered DATA, ID and LAST=(count==LEN). RESP=10 if the beat is out of range or BURST=11, with DATA=0; otherwise 00.
  - All outputs are held stable until RD_DATA_READY. On handshake, go to R_IDLE if LAST, else advance the address and go to R_FETCH.
  - Latency: AR handshake at cycle t gives first RVALID at t+2. Throughput is 1 beat per 2 cycles with READY held high.
  - RD_DATA, RD_BACK_ID, RD_DATA_RESP and RD_DATA_LAST are forced to 0 whenever RD_DATA_VALID=0.
- Concurrency:
  - Write and read engines run concurrently.
  - A write and an R_FETCH read to the same word in the same cycle: the read returns the old data (read-first).
- LEN=255 gives 256 beats, so the beat counter is 8 bits and compared against LEN.

Test Plan:
- INCR write, addr 0x10, LEN=3, data 0xA0..0xA3, STRB=F, LAST on beat 3 -> BACK ID echoed, RESP=00. Then INCR read of the same range -> 4 beats 0xA0..0xA3, LAST only on beat 3, first RVALID 2 cycles after the AR handshake.
- Write 0xFFFF_FFFF to addr 0x20, then a single-beat write of 0x1234_5678 with STRB=0101 -> read of 0x20 returns 0xFF34_FF78.
- FIXED write, LEN=2, data 1, 2, 3 to addr 0x40 -> a read of 0x40 returns 3; RESP=00.
- INCR write starting at the last RAM word (0xFFC, MEM_AW=10), LEN=1 -> RESP=10, word 0xFFC updated. INCR read of the same -> beat 0 RESP=00, beat 1 RESP=10 with DATA=0.
- Write with LAST asserted on beat 1 of LEN=3 -> all 4 beats accepted, RESP=10. Separately, BURST=11 -> RESP=10.
- Hold RD_DATA_READY low for 5 cycles mid-burst -> data, ID and LAST stay stable, no beat is lost. Assert S_RST during W_DATA -> next cycle all VALID/READY=0, no response ever issued, a new burst then completes with OKAY.
